sram_bus_arbiter: RTL and testbench

Parametrised N-master to 1-slave arbiter for the internal SRAM-style bus (read: addr/type/req → rdy, then data/valid; write: addr/data/type/strb/req → rdy). It is the successor to the fixed four-port interconnect: master count, widths and arbitration mode are parameters. Read and write channels are arbitrated independently, with a per-channel grant lock. It sits between the cache/LSU request ports and `mem2axi`.

---
 rtl/sram_bus_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/sram_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// rtl/sram_bus_pkg.sv - shared constants, FSM encodings and helpers for the SRAM bus arbiter
package sram_bus_pkg;

  localparam int SRAM_AW = 32;
  localparam int SRAM_DW = 256;
  localparam int SRAM_TW = 6;
  localparam int SRAM_SW = 16;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_REQ  = 1'b1
  } wr_state_e;

  // Request types as issued by the I/D caches and the LSU
  localparam logic [SRAM_TW-1:0] TYPE_LINE_FILL  = 6'h01;
  localparam logic [SRAM_TW-1:0] TYPE_LINE_EVICT = 6'h02;
  localparam logic [SRAM_TW-1:0] TYPE_UNCACHED   = 6'h04;
  localparam logic [SRAM_TW-1:0] TYPE_IFETCH     = 6'h08;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot arbiter, round-robin from ptr or fixed lowest-index priority
module rr_arbiter import sram_bus_pkg::*; #(
  parameter int N    = 4,
  parameter int PRIO = 0,
  parameter int PW   = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;
  int   start;

  // Outer loop walks priority order, inner loop finds the master at that slot
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    start = (PRIO != 0) ? 0 : int'(ptr);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == (start + i) % N)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - N-master to 1-slave SRAM bus arbiter with independent read/write channels
module sram_bus_arbiter import sram_bus_pkg::*; #(
  parameter int N    = 4,
  parameter int AW   = SRAM_AW,
  parameter int DW   = SRAM_DW,
  parameter int TW   = SRAM_TW,
  parameter int SW   = SRAM_SW,
  parameter int PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]    m_r_req,
  input  logic [N*AW-1:0] m_r_addr,
  input  logic [N*TW-1:0] m_r_type,
  output logic [N-1:0]    m_r_rdy,
  output logic [DW-1:0]   m_re_data,
  output logic [N-1:0]    m_re_valid,
  input  logic [N-1:0]    m_w_req,
  input  logic [N*AW-1:0] m_w_addr,
  input  logic [N*DW-1:0] m_w_data,
  input  logic [N*TW-1:0] m_w_type,
  input  logic [N*SW-1:0] m_w_strb,
  output logic [N-1:0]    m_w_rdy,
  output logic          s_r_req,
  output logic [AW-1:0] s_r_addr,
  output logic [TW-1:0] s_r_type,
  input  logic          s_r_rdy,
  input  logic [DW-1:0] s_re_data,
  input  logic          s_re_valid,
  output logic          s_w_req,
  output logic [AW-1:0] s_w_addr,
  output logic [DW-1:0] s_w_data,
  output logic [TW-1:0] s_w_type,
  output logic [SW-1:0] s_w_strb,
  input  logic          s_w_rdy
);

  localparam int PW = ptr_width(N);

  rd_state_e     r_state_q, r_state_d;
  wr_state_e     w_state_q, w_state_d;
  logic [N-1:0]  r_gnt_q, r_gnt_d, w_gnt_q, w_gnt_d;
  logic [N-1:0]  r_arb_gnt, w_arb_gnt;
  logic [PW-1:0] r_ptr_q, r_ptr_d, w_ptr_q, w_ptr_d;

  rr_arbiter #(.N(N), .PRIO(PRIO), .PW(PW)) u_r_arb (
    .req(m_r_req), .ptr(r_ptr_q), .gnt(r_arb_gnt)
  );

  rr_arbiter #(.N(N), .PRIO(PRIO), .PW(PW)) u_w_arb (
    .req(m_w_req), .ptr(w_ptr_q), .gnt(w_arb_gnt)
  );

  function automatic logic [PW-1:0] next_ptr(input logic [N-1:0] gnt);
    next_ptr = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      r_gnt_q   <= '0;
      w_gnt_q   <= '0;
      r_ptr_q   <= '0;
      w_ptr_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      r_gnt_q   <= r_gnt_d;
      w_gnt_q   <= w_gnt_d;
      r_ptr_q   <= r_ptr_d;
      w_ptr_q   <= w_ptr_d;
    end
  end

  // Grants and pointers only move in IDLE, which is what locks a channel to its owner
  always_comb begin
    r_state_d = r_state_q;
    r_gnt_d   = r_gnt_q;
    r_ptr_d   = r_ptr_q;
    case (r_state_q)
      R_IDLE: begin
        if (|m_r_req) begin
          r_gnt_d   = r_arb_gnt;
          r_ptr_d   = next_ptr(r_arb_gnt);
          r_state_d = R_REQ;
        end
      end
      R_REQ:   if (s_r_rdy) r_state_d = s_re_valid ? R_IDLE : R_WAIT;
      R_WAIT:  if (s_re_valid) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_gnt_d   = w_gnt_q;
    w_ptr_d   = w_ptr_q;
    case (w_state_q)
      W_IDLE: begin
        if (|m_w_req) begin
          w_gnt_d   = w_arb_gnt;
          w_ptr_d   = next_ptr(w_arb_gnt);
          w_state_d = W_REQ;
        end
      end
      W_REQ:   if (s_w_rdy) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Outputs are forced low while rst_n is asserted, even before the state register clears
  always_comb begin
    s_r_req    = 1'b0;
    s_r_addr   = '0;
    s_r_type   = '0;
    m_r_rdy    = '0;
    m_re_valid = '0;
    if (rst_n) begin
      case (r_state_q)
        R_REQ: begin
          s_r_req = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (r_gnt_q[i]) begin
              s_r_addr = m_r_addr[i*AW +: AW];
              s_r_type = m_r_type[i*TW +: TW];
            end
          end
          if (s_r_rdy) begin
            m_r_rdy = r_gnt_q;
            if (s_re_valid) m_re_valid = r_gnt_q;
          end
        end
        R_WAIT:  if (s_re_valid) m_re_valid = r_gnt_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    s_w_req  = 1'b0;
    s_w_addr = '0;
    s_w_data = '0;
    s_w_type = '0;
    s_w_strb = '0;
    m_w_rdy  = '0;
    if (rst_n && (w_state_q == W_REQ)) begin
      s_w_req = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (w_gnt_q[i]) begin
          s_w_addr = m_w_addr[i*AW +: AW];
          s_w_data = m_w_data[i*DW +: DW];
          s_w_type = m_w_type[i*TW +: TW];
          s_w_strb = m_w_strb[i*SW +: SW];
        end
      end
      if (s_w_rdy) m_w_rdy = w_gnt_q;
    end
  end

  assign m_re_data = rst_n ? s_re_data : '0;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - directed self-checking bench for sram_bus_arbiter
module tb_sram_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TW = 6;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [N-1:0]    m_r_req, m_w_req;
  logic [N*AW-1:0] m_r_addr, m_w_addr;
  logic [N*TW-1:0] m_r_type, m_w_type;
  logic [N*DW-1:0] m_w_data;
  logic [N*SW-1:0] m_w_strb;
  logic            s_r_rdy, s_re_valid, s_w_rdy;
  logic [DW-1:0]   s_re_data;

  logic [N-1:0]  a_m_r_rdy, a_m_re_valid, a_m_w_rdy, b_m_r_rdy, b_m_re_valid, b_m_w_rdy;
  logic [DW-1:0] a_m_re_data, b_m_re_data, a_s_w_data, b_s_w_data;
  logic          a_s_r_req, a_s_w_req, b_s_r_req, b_s_w_req;
  logic [AW-1:0] a_s_r_addr, a_s_w_addr, b_s_r_addr, b_s_w_addr;
  logic [TW-1:0] a_s_r_type, a_s_w_type, b_s_r_type, b_s_w_type;
  logic [SW-1:0] a_s_w_strb, b_s_w_strb;

  logic [0:0]    c_m_r_req, c_m_w_req, c_m_r_rdy, c_m_re_valid, c_m_w_rdy;
  logic [AW-1:0] c_m_r_addr, c_m_w_addr, c_s_r_addr, c_s_w_addr;
  logic [TW-1:0] c_m_r_type, c_m_w_type, c_s_r_type, c_s_w_type;
  logic [DW-1:0] c_m_w_data, c_m_re_data, c_s_w_data;
  logic [SW-1:0] c_m_w_strb, c_s_w_strb;
  logic          c_s_r_req, c_s_w_req;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.N(N), .AW(AW), .DW(DW), .TW(TW), .SW(SW), .PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(a_m_r_rdy),
    .m_re_data(a_m_re_data), .m_re_valid(a_m_re_valid),
    .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_type(m_w_type),
    .m_w_strb(m_w_strb), .m_w_rdy(a_m_w_rdy),
    .s_r_req(a_s_r_req), .s_r_addr(a_s_r_addr), .s_r_type(a_s_r_type), .s_r_rdy(s_r_rdy),
    .s_re_data(s_re_data), .s_re_valid(s_re_valid),
    .s_w_req(a_s_w_req), .s_w_addr(a_s_w_addr), .s_w_data(a_s_w_data), .s_w_type(a_s_w_type),
    .s_w_strb(a_s_w_strb), .s_w_rdy(s_w_rdy)
  );

  sram_bus_arbiter #(.N(N), .AW(AW), .DW(DW), .TW(TW), .SW(SW), .PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(b_m_r_rdy),
    .m_re_data(b_m_re_data), .m_re_valid(b_m_re_valid),
    .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_type(m_w_type),
    .m_w_strb(m_w_strb), .m_w_rdy(b_m_w_rdy),
    .s_r_req(b_s_r_req), .s_r_addr(b_s_r_addr), .s_r_type(b_s_r_type), .s_r_rdy(s_r_rdy),
    .s_re_data(s_re_data), .s_re_valid(s_re_valid),
    .s_w_req(b_s_w_req), .s_w_addr(b_s_w_addr), .s_w_data(b_s_w_data), .s_w_type(b_s_w_type),
    .s_w_strb(b_s_w_strb), .s_w_rdy(s_w_rdy)
  );

  sram_bus_arbiter #(.N(1), .AW(AW), .DW(DW), .TW(TW), .SW(SW), .PRIO(0)) u_n1 (
    .clk(clk), .rst_n(rst_n),
    .m_r_req(c_m_r_req), .m_r_addr(c_m_r_addr), .m_r_type(c_m_r_type), .m_r_rdy(c_m_r_rdy),
    .m_re_data(c_m_re_data), .m_re_valid(c_m_re_valid),
    .m_w_req(c_m_w_req), .m_w_addr(c_m_w_addr), .m_w_data(c_m_w_data), .m_w_type(c_m_w_type),
    .m_w_strb(c_m_w_strb), .m_w_rdy(c_m_w_rdy),
    .s_r_req(c_s_r_req), .s_r_addr(c_s_r_addr), .s_r_type(c_s_r_type), .s_r_rdy(s_r_rdy),
    .s_re_data(s_re_data), .s_re_valid(s_re_valid),
    .s_w_req(c_s_w_req), .s_w_addr(c_s_w_addr), .s_w_data(c_s_w_data), .s_w_type(c_s_w_type),
    .s_w_strb(c_s_w_strb), .s_w_rdy(s_w_rdy)
  );

  function automatic logic [AW-1:0] raddr(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [AW-1:0] waddr(input int i);
    return 32'h2000_0000 + 32'(i) * 32'h100;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_r_req = '0; m_w_req = '0; m_r_type = '0; m_w_type = '0; m_w_data = '0; m_w_strb = '0;
    for (int i = 0; i < N; i++) begin
      m_r_addr[i*AW +: AW] = raddr(i);
      m_w_addr[i*AW +: AW] = waddr(i);
    end
    s_r_rdy = 1'b0; s_re_valid = 1'b0; s_w_rdy = 1'b0; s_re_data = '0;
    c_m_r_req = '0; c_m_r_addr = '0; c_m_r_type = '0;
    c_m_w_req = '0; c_m_w_addr = '0; c_m_w_data = '0; c_m_w_type = '0; c_m_w_strb = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    m_r_req = '1; m_w_req = '1; s_r_rdy = 1'b1; s_w_rdy = 1'b1; s_re_valid = 1'b1;
    s_re_data = {8{32'hA5A5_5A5A}};
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({a_s_r_req, a_s_w_req, a_s_r_addr, a_s_w_addr, a_s_w_strb, a_s_w_type} !== '0) begin
      failures++;
      $display("FAIL reset_s_fields: got=%h required=0",
               {a_s_r_req, a_s_w_req, a_s_r_addr, a_s_w_addr, a_s_w_strb, a_s_w_type});
    end
    checks++;
    if (a_m_re_data !== '0) begin
      failures++;
      $display("FAIL reset_m_re_data: got=%h required=0", a_m_re_data);
    end
    checks++;
    if ({a_m_r_rdy, a_m_re_valid, a_m_w_rdy, a_s_w_data} !== '0) begin
      failures++;
      $display("FAIL reset_m_handshakes: got=%h required=0", {a_m_r_rdy, a_m_re_valid, a_m_w_rdy});
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  exp_gnt;
    logic [DW-1:0] exp_data;
    do_reset();
    m_r_req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      exp_gnt  = 4'(1 << k);
      exp_data = {8{32'hC0DE_0000 + 32'(k)}};
      tick(); s_r_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if ({a_s_r_req, a_m_r_rdy, a_s_r_addr} !== {1'b1, exp_gnt, raddr(k)}) begin
        failures++;
        $display("FAIL rr_grant%0d: got req/rdy/addr=%h required=%h", k,
                 {a_s_r_req, a_m_r_rdy, a_s_r_addr}, {1'b1, exp_gnt, raddr(k)});
      end
      tick(); s_r_rdy = 1'b0; m_r_req[k] = 1'b0; s_re_valid = 1'b1; s_re_data = exp_data;
      @(negedge clk);
      checks++;
      if ({a_m_re_valid, a_m_r_rdy, a_m_re_data} !== {exp_gnt, 4'b0000, exp_data}) begin
        failures++;
        $display("FAIL rr_valid%0d: got valid=%b rdy=%b data=%h required valid=%b", k,
                 a_m_re_valid, a_m_r_rdy, a_m_re_data, exp_gnt);
      end
      tick(); s_re_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (a_s_r_req !== 1'b0) begin
        failures++;
        $display("FAIL rr_gap%0d: got s_r_req=%b required=0", k, a_s_r_req);
      end
    end
  endtask

  task automatic test_fixed_priority();
    logic [N-1:0] exp_b, exp_a;
    do_reset();
    m_r_req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      exp_b = (k == 3) ? 4'b1000 : 4'b0010;
      exp_a = (k == 1 || k == 3) ? 4'b1000 : 4'b0010;
      tick(); s_r_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if ({b_m_r_rdy, a_m_r_rdy} !== {exp_b, exp_a}) begin
        failures++;
        $display("FAIL prio_grant%0d: got fp=%b rr=%b required fp=%b rr=%b", k,
                 b_m_r_rdy, a_m_r_rdy, exp_b, exp_a);
      end
      tick(); s_r_rdy = 1'b0; s_re_valid = 1'b1;
      if (k == 3) m_r_req = '0;
      @(negedge clk);
      checks++;
      if (b_m_re_valid !== exp_b) begin
        failures++;
        $display("FAIL prio_valid%0d: got=%b required=%b", k, b_m_re_valid, exp_b);
      end
      tick(); s_re_valid = 1'b0;
      if (k == 2) m_r_req = 4'b1000;
    end
  endtask

  task automatic test_concurrent();
    do_reset();
    m_r_addr[0 +: AW] = 32'h8000_0000;
    m_r_type[0 +: TW] = 6'h01;
    m_w_addr[2*AW +: AW] = 32'h8000_0040;
    m_w_strb[2*SW +: SW] = 16'h00FF;
    m_w_type[2*TW +: TW] = 6'h02;
    m_w_data[2*DW +: DW] = {8{32'h1234_5678}};
    m_r_req = 4'b0001;
    m_w_req = 4'b0100;
    tick(); s_w_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_s_r_req, a_s_r_addr, a_s_r_type} !== {1'b1, 32'h8000_0000, 6'h01}) begin
      failures++;
      $display("FAIL conc_read_fields: got=%h required=%h",
               {a_s_r_req, a_s_r_addr, a_s_r_type}, {1'b1, 32'h8000_0000, 6'h01});
    end
    checks++;
    if ({a_s_w_req, a_s_w_addr, a_s_w_strb, a_s_w_type} !== {1'b1, 32'h8000_0040, 16'h00FF, 6'h02}) begin
      failures++;
      $display("FAIL conc_write_fields: got=%h required=%h",
               {a_s_w_req, a_s_w_addr, a_s_w_strb, a_s_w_type}, {1'b1, 32'h8000_0040, 16'h00FF, 6'h02});
    end
    checks++;
    if (a_s_w_data !== {8{32'h1234_5678}}) begin
      failures++;
      $display("FAIL conc_write_data: got=%h", a_s_w_data);
    end
    checks++;
    if ({a_m_w_rdy, a_m_r_rdy} !== {4'b0100, 4'b0000}) begin
      failures++;
      $display("FAIL conc_w_rdy: got w=%b r=%b required w=0100 r=0000", a_m_w_rdy, a_m_r_rdy);
    end
    tick(); s_w_rdy = 1'b0; m_w_req = '0; s_r_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_m_r_rdy, a_m_w_rdy, a_s_w_req} !== {4'b0001, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL conc_r_rdy: got r=%b w=%b s_w_req=%b required r=0001 w=0000 s_w_req=0",
               a_m_r_rdy, a_m_w_rdy, a_s_w_req);
    end
    tick(); s_r_rdy = 1'b0; m_r_req = '0; s_re_valid = 1'b1; s_re_data = {8{32'h0BAD_F00D}};
    @(negedge clk);
    checks++;
    if ({a_m_re_valid, a_m_w_rdy} !== {4'b0001, 4'b0000}) begin
      failures++;
      $display("FAIL conc_r_valid: got valid=%b w=%b required valid=0001 w=0000", a_m_re_valid, a_m_w_rdy);
    end
    tick(); s_re_valid = 1'b0;
  endtask

  task automatic test_rdy_valid_together();
    do_reset();
    m_r_req = 4'b0100;
    tick(); s_r_rdy = 1'b1; s_re_valid = 1'b1; s_re_data = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    checks++;
    if ({a_m_r_rdy, a_m_re_valid, a_m_re_data} !== {4'b0100, 4'b0100, {8{32'hDEAD_BEEF}}}) begin
      failures++;
      $display("FAIL rv_same_cycle: got rdy=%b valid=%b data=%h required rdy=0100 valid=0100",
               a_m_r_rdy, a_m_re_valid, a_m_re_data);
    end
    tick(); s_r_rdy = 1'b0; m_r_req = '0;
    @(negedge clk);
    checks++;
    if ({a_s_r_req, a_m_re_valid} !== {1'b0, 4'b0000}) begin
      failures++;
      $display("FAIL rv_back_to_idle: got s_r_req=%b valid=%b required 0/0000", a_s_r_req, a_m_re_valid);
    end
    tick(); s_re_valid = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m_r_req = 4'b0010;
    tick(); s_r_rdy = 1'b1;
    tick(); s_r_rdy = 1'b0; m_r_req = '0;
    tick(); rst_n = 1'b0; m_r_req = 4'b1111; s_re_data = {8{32'h7777_1111}};
    @(negedge clk);
    checks++;
    if ({a_s_r_req, a_m_r_rdy, a_m_re_valid, a_m_re_data, a_s_r_addr} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got s_r_req=%b rdy=%b valid=%b data=%h",
               a_s_r_req, a_m_r_rdy, a_m_re_valid, a_m_re_data);
    end
    tick(); s_re_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_m_re_valid, a_m_re_data} !== '0) begin
      failures++;
      $display("FAIL midrst_valid_in_reset: got valid=%b data=%h required 0", a_m_re_valid, a_m_re_data);
    end
    tick(); rst_n = 1'b1; m_r_req = 4'b1101;
    @(negedge clk);
    checks++;
    if ({a_m_re_valid, a_s_r_req} !== {4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL midrst_stray_valid: got valid=%b s_r_req=%b required 0000/0", a_m_re_valid, a_s_r_req);
    end
    tick(); s_re_valid = 1'b0; s_r_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_m_r_rdy, a_s_r_addr} !== {4'b0001, raddr(0)}) begin
      failures++;
      $display("FAIL midrst_first_grant: got rdy=%b addr=%h required rdy=0001 addr=%h",
               a_m_r_rdy, a_s_r_addr, raddr(0));
    end
    tick(); s_r_rdy = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    m_w_req = 4'b0100;
    tick(); s_w_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (a_m_w_rdy !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_first: got=%b required=0100", a_m_w_rdy);
    end
    tick(); s_w_rdy = 1'b0; m_w_req = 4'b1001;
    @(negedge clk);
    checks++;
    if (a_s_w_req !== 1'b0) begin
      failures++;
      $display("FAIL wrap_gap: got s_w_req=%b required=0", a_s_w_req);
    end
    tick(); s_w_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_m_w_rdy, a_s_w_addr, b_m_w_rdy} !== {4'b1000, waddr(3), 4'b0001}) begin
      failures++;
      $display("FAIL wrap_ptr3: got rr=%b addr=%h fp=%b required rr=1000 addr=%h fp=0001",
               a_m_w_rdy, a_s_w_addr, b_m_w_rdy, waddr(3));
    end
    tick(); s_w_rdy = 1'b0; m_w_req = 4'b0001;
    tick(); s_w_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_m_w_rdy, a_s_w_addr} !== {4'b0001, waddr(0)}) begin
      failures++;
      $display("FAIL wrap_to0: got rdy=%b addr=%h required rdy=0001 addr=%h", a_m_w_rdy, a_s_w_addr, waddr(0));
    end
    tick(); s_w_rdy = 1'b0; m_w_req = '0;
  endtask

  task automatic test_n1();
    do_reset();
    c_m_w_req = 1'b1; c_m_w_addr = 32'h4000_0100; c_m_w_strb = 16'hF00F;
    c_m_w_type = 6'h02; c_m_w_data = {8{32'hCAFE_0001}};
    tick(); s_w_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({c_s_w_req, c_s_w_addr, c_s_w_strb, c_s_w_type, c_m_w_rdy} !==
        {1'b1, 32'h4000_0100, 16'hF00F, 6'h02, 1'b1}) begin
      failures++;
      $display("FAIL n1_first: got req=%b addr=%h strb=%h rdy=%b", c_s_w_req, c_s_w_addr, c_s_w_strb, c_m_w_rdy);
    end
    tick(); s_w_rdy = 1'b0; c_m_w_addr = 32'h4000_0200;
    @(negedge clk);
    checks++;
    if ({c_s_w_req, c_m_w_rdy} !== 2'b00) begin
      failures++;
      $display("FAIL n1_gap: got req=%b rdy=%b required 0/0", c_s_w_req, c_m_w_rdy);
    end
    tick(); s_w_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({c_s_w_req, c_s_w_addr, c_m_w_rdy} !== {1'b1, 32'h4000_0200, 1'b1}) begin
      failures++;
      $display("FAIL n1_second: got req=%b addr=%h rdy=%b", c_s_w_req, c_s_w_addr, c_m_w_rdy);
    end
    tick(); s_w_rdy = 1'b0; c_m_w_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_concurrent();
    test_rdy_valid_together();
    test_reset_mid_read();
    test_wrap();
    test_n1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
